// File: rtl/pbus_arb2_pkg.sv
// Shared definitions for the two-master peripheral bus arbiter:
// state encoding and default slave bus widths.
package pbus_arb2_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC0 = 2'd1,
    ACC1 = 2'd2
  } state_t;

  localparam int DEF_AW = 3;
  localparam int DEF_DW = 32;

endpackage

// File: rtl/pbus_arb2.sv
// Round-robin arbiter sharing one peripheral slave port between two masters,
// with a bounded lock that lets a master keep the bus for short bursts.
module pbus_arb2
  import pbus_arb2_pkg::*;
#(
  parameter int AW        = DEF_AW,
  parameter int DW        = DEF_DW,
  parameter int MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic          m0_lock,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_din,
  output logic          m0_ack,
  output logic [DW-1:0] m0_dout,
  input  logic          m1_req,
  input  logic          m1_lock,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_din,
  output logic          m1_ack,
  output logic [DW-1:0] m1_dout,
  output logic          s_ce,
  output logic          s_we,
  output logic [AW-1:0] s_addr,
  output logic [DW-1:0] s_din,
  input  logic [DW-1:0] s_dout
);

  localparam logic [3:0] BURST_LIM = 4'(MAX_BURST - 1);

  state_t     state;
  logic       last;
  logic [3:0] burst_cnt;

  logic own;
  logic own_req;
  logic oth_req;
  logic own_lock;

  // View the current owner's request/lock versus the competitor's, so both
  // ACC states share one decision path.
  always_comb begin
    own      = (state == ACC1);
    own_req  = own ? m1_req  : m0_req;
    oth_req  = own ? m0_req  : m1_req;
    own_lock = own ? m1_lock : m0_lock;
  end

  // Grant FSM; `last` remembers who was served most recently so that a tie
  // out of IDLE goes to the other master.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      last      <= 1'b1;
      burst_cnt <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          burst_cnt <= 4'd0;
          if (m0_req && (!m1_req || last)) begin
            state <= ACC0;
            last  <= 1'b0;
          end else if (m1_req) begin
            state <= ACC1;
            last  <= 1'b1;
          end
        end
        ACC0, ACC1: begin
          if (own_req && oth_req && own_lock && (burst_cnt < BURST_LIM)) begin
            burst_cnt <= burst_cnt + 4'd1;
            last      <= own;
          end else if (own_req && !oth_req) begin
            burst_cnt <= 4'd0;
            last      <= own;
          end else if (oth_req) begin
            state     <= own ? ACC0 : ACC1;
            last      <= !own;
            burst_cnt <= 4'd0;
          end else begin
            state     <= IDLE;
            burst_cnt <= 4'd0;
          end
        end
        default: begin
          state     <= IDLE;
          burst_cnt <= 4'd0;
        end
      endcase
    end
  end

  // Bus steering depends only on the registered state, so an asynchronous
  // reset drops s_ce and the acks immediately.
  always_comb begin
    s_ce    = 1'b0;
    s_we    = 1'b0;
    s_addr  = '0;
    s_din   = '0;
    m0_ack  = 1'b0;
    m1_ack  = 1'b0;
    m0_dout = '0;
    m1_dout = '0;
    case (state)
      ACC0: begin
        s_ce    = 1'b1;
        s_we    = m0_we;
        s_addr  = m0_addr;
        s_din   = m0_din;
        m0_ack  = 1'b1;
        m0_dout = s_dout;
      end
      ACC1: begin
        s_ce    = 1'b1;
        s_we    = m1_we;
        s_addr  = m1_addr;
        s_din   = m1_din;
        m1_ack  = 1'b1;
        m1_dout = s_dout;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_pbus_arb2.sv
// Directed, table-driven bench for pbus_arb2 with hand-written sequences
// for lock bursts and reset during an access.
module tb_pbus_arb2;
  import pbus_arb2_pkg::*;

  localparam int AW = 3;
  localparam int DW = 32;
  localparam int MAX_BURST = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          m0_req, m0_lock, m0_we;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_din;
  logic          m0_ack;
  logic [DW-1:0] m0_dout;
  logic          m1_req, m1_lock, m1_we;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_din;
  logic          m1_ack;
  logic [DW-1:0] m1_dout;
  logic          s_ce, s_we;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_din;
  logic [DW-1:0] s_dout;

  int tests = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pbus_arb2 #(.AW(AW), .DW(DW), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_lock(m0_lock), .m0_we(m0_we), .m0_addr(m0_addr),
    .m0_din(m0_din), .m0_ack(m0_ack), .m0_dout(m0_dout),
    .m1_req(m1_req), .m1_lock(m1_lock), .m1_we(m1_we), .m1_addr(m1_addr),
    .m1_din(m1_din), .m1_ack(m1_ack), .m1_dout(m1_dout),
    .s_ce(s_ce), .s_we(s_we), .s_addr(s_addr), .s_din(s_din), .s_dout(s_dout)
  );

  typedef struct {
    logic          m0_req, m0_lock, m0_we;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_din;
    logic          m1_req, m1_lock, m1_we;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_din;
    logic [DW-1:0] s_dout;
    logic          ce, we;
    logic [AW-1:0] addr;
    logic [DW-1:0] din;
    logic          ack0, ack1;
    logic [DW-1:0] dout0, dout1;
  } vec_t;

  localparam logic [DW-1:0] DA = 32'hA5A5_0003;
  localparam logic [DW-1:0] DB = 32'h5A5A_0005;
  localparam logic [DW-1:0] RD = 32'h1234_5678;

  vec_t vecs[$];

  function automatic vec_t mk(
    input logic r0, input logic l0, input logic w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
    input logic r1, input logic l1, input logic w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
    input logic [DW-1:0] sd,
    input logic ce, input logic we, input logic [AW-1:0] ad, input logic [DW-1:0] di,
    input logic k0, input logic k1, input logic [DW-1:0] o0, input logic [DW-1:0] o1);
    vec_t v;
    v.m0_req = r0; v.m0_lock = l0; v.m0_we = w0; v.m0_addr = a0; v.m0_din = d0;
    v.m1_req = r1; v.m1_lock = l1; v.m1_we = w1; v.m1_addr = a1; v.m1_din = d1;
    v.s_dout = sd;
    v.ce = ce; v.we = we; v.addr = ad; v.din = di;
    v.ack0 = k0; v.ack1 = k1; v.dout0 = o0; v.dout1 = o1;
    return v;
  endfunction

  task automatic check_output(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp_v);
    tests++;
    if (act !== exp_v) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp_v);
    end
  endtask

  task automatic apply_stimulus(input vec_t v);
    m0_req = v.m0_req; m0_lock = v.m0_lock; m0_we = v.m0_we; m0_addr = v.m0_addr; m0_din = v.m0_din;
    m1_req = v.m1_req; m1_lock = v.m1_lock; m1_we = v.m1_we; m1_addr = v.m1_addr; m1_din = v.m1_din;
    s_dout = v.s_dout;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_vec(input int i, input vec_t v);
    check_output($sformatf("v%0d s_ce", i), 32'(s_ce), 32'(v.ce));
    check_output($sformatf("v%0d s_we", i), 32'(s_we), 32'(v.we));
    check_output($sformatf("v%0d s_addr", i), 32'(s_addr), 32'(v.addr));
    check_output($sformatf("v%0d s_din", i), s_din, v.din);
    check_output($sformatf("v%0d m0_ack", i), 32'(m0_ack), 32'(v.ack0));
    check_output($sformatf("v%0d m1_ack", i), 32'(m1_ack), 32'(v.ack1));
    check_output($sformatf("v%0d m0_dout", i), m0_dout, v.dout0);
    check_output($sformatf("v%0d m1_dout", i), m1_dout, v.dout1);
  endtask

  initial begin
    int got;
    // Single transfers, round-robin alternation, then a locked burst of MAX_BURST.
    vecs.push_back(mk(1,0,1,3'd0,32'd1, 0,0,0,3'd0,32'd0, 32'd0, 1,1,3'd0,32'd1, 1,0,32'd0,32'd0));
    vecs.push_back(mk(0,0,0,3'd0,32'd0, 0,0,0,3'd0,32'd0, 32'd0, 0,0,3'd0,32'd0, 0,0,32'd0,32'd0));
    vecs.push_back(mk(0,0,0,3'd0,32'd0, 1,0,0,3'd0,32'd0, 32'd1, 1,0,3'd0,32'd0, 0,1,32'd0,32'd1));
    vecs.push_back(mk(0,0,0,3'd0,32'd0, 0,0,0,3'd0,32'd0, 32'd1, 0,0,3'd0,32'd0, 0,0,32'd0,32'd0));
    vecs.push_back(mk(1,0,1,3'd3,DA, 1,0,1,3'd5,DB, RD, 1,1,3'd3,DA, 1,0,RD,32'd0));
    vecs.push_back(mk(1,0,1,3'd3,DA, 1,0,1,3'd5,DB, RD, 1,1,3'd5,DB, 0,1,32'd0,RD));
    vecs.push_back(mk(1,0,1,3'd3,DA, 1,0,1,3'd5,DB, RD, 1,1,3'd3,DA, 1,0,RD,32'd0));
    vecs.push_back(mk(1,0,1,3'd3,DA, 1,0,1,3'd5,DB, RD, 1,1,3'd5,DB, 0,1,32'd0,RD));
    vecs.push_back(mk(0,0,0,3'd0,32'd0, 0,0,0,3'd0,32'd0, RD, 0,0,3'd0,32'd0, 0,0,32'd0,32'd0));
    vecs.push_back(mk(1,1,0,3'd2,DA, 1,0,1,3'd6,DB, RD, 1,0,3'd2,DA, 1,0,RD,32'd0));
    vecs.push_back(mk(1,1,0,3'd2,DA, 1,0,1,3'd6,DB, RD, 1,0,3'd2,DA, 1,0,RD,32'd0));
    vecs.push_back(mk(1,1,0,3'd2,DA, 1,0,1,3'd6,DB, RD, 1,0,3'd2,DA, 1,0,RD,32'd0));
    vecs.push_back(mk(1,1,0,3'd2,DA, 1,0,1,3'd6,DB, RD, 1,0,3'd2,DA, 1,0,RD,32'd0));
    vecs.push_back(mk(1,1,0,3'd2,DA, 1,0,1,3'd6,DB, RD, 1,1,3'd6,DB, 0,1,32'd0,RD));
    vecs.push_back(mk(1,1,0,3'd2,DA, 1,0,1,3'd6,DB, RD, 1,0,3'd2,DA, 1,0,RD,32'd0));
    vecs.push_back(mk(0,0,0,3'd0,32'd0, 0,0,0,3'd0,32'd0, RD, 0,0,3'd0,32'd0, 0,0,32'd0,32'd0));

    rst = 1'b1;
    apply_stimulus(mk(0,0,0,3'd0,32'd0, 0,0,0,3'd0,32'd0, 32'd0, 0,0,3'd0,32'd0, 0,0,32'd0,32'd0));
    repeat (2) step();
    check_vec(-1, mk(0,0,0,3'd0,32'd0, 0,0,0,3'd0,32'd0, 32'd0, 0,0,3'd0,32'd0, 0,0,32'd0,32'd0));
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      apply_stimulus(vecs[i]);
      step();
      check_vec(i, vecs[i]);
    end

    // Lock with no competitor: unlimited back-to-back transfers.
    apply_stimulus(mk(1,1,1,3'd1,DA, 0,0,0,3'd4,DB, RD, 0,0,3'd0,32'd0, 0,0,32'd0,32'd0));
    for (int i = 0; i < 10; i++) begin
      step();
      check_output($sformatf("solo_lock c%0d m0_ack", i), 32'(m0_ack), 32'd1);
    end

    // Competitor arrives: lock must yield within MAX_BURST transfers.
    m1_req = 1'b1;
    got = 0;
    for (int i = 0; i < MAX_BURST + 1 && got == 0; i++) begin
      step();
      if (m1_ack) got = i + 1;
    end
    check_output("lock_yield cycles", 32'(got), 32'(MAX_BURST));
    check_output("lock_yield s_addr", 32'(s_addr), 32'd4);

    // Reset during ACC1 drops the bus asynchronously; m0 then wins the tie.
    rst = 1'b1;
    #1;
    check_output("rst_mid s_ce", 32'(s_ce), 32'd0);
    check_output("rst_mid m1_ack", 32'(m1_ack), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    m0_lock = 1'b0;
    step();
    check_output("post_rst m0_ack", 32'(m0_ack), 32'd1);
    check_output("post_rst m1_ack", 32'(m1_ack), 32'd0);
    step();
    check_output("post_rst next m1_ack", 32'(m1_ack), 32'd1);

    m0_req = 1'b0;
    m1_req = 1'b0;
    step();
    step();
    check_output("final idle s_ce", 32'(s_ce), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
